cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- 8-phase instruction sequencer for the 8-bit accumulator CPU.
- Consumes the 3-bit opcode from the instruction register and the ALU `is_zero` flag.
- Drives the control strobes for the PC, the IR, the accumulator, the memory bus and the address mux that surround the ALU.
- One instruction takes exactly 8 clocks; HLT freezes the sequencer until reset.

Parameters:
- HALT_STICKY, 1: 1 = HLT freezes the sequencer until reset; 0 = halt is a one-phase pulse and sequencing continues.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  3  IR opcode field; `OPCODE_HLT`..`OPCODE_JMP` = 0..7.
- is_zero  in  1  ALU zero flag (accumulator == 0).
- sel  out  1  address mux: 1 = PC, 0 = IR operand.
- rd  out  1  memory read enable.
- ld_ir  out  1  load IR from data bus.
- inc_pc  out  1  increment PC.
- ld_pc  out  1  load PC from IR operand.
- ld_ac  out  1  load accumulator from ALU out.
- data_e  out  1  drive ALU out onto data bus.
- wr  out  1  memory write strobe.
- halt  out  1  CPU halted.
- phase  out  3  current phase, for debug and verification.

Behaviour:
- Reset and clock domain
  - Single clock domain.
  - rst asserts asynchronously: phase=0 (INST_ADDR), halted flag=0.
  - Outputs during and after reset: sel=1, all other strobes 0, halt=0.
- Phase register
  - 3-bit; advances by 1 each clk and wraps 7->0.
  - Does not advance while the halted flag is set.
  - Phase names: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Output decode
  - Outputs are combinational from (phase, opcode, is_zero, halted); no extra latency.
  - ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Per-phase outputs (unlisted strobes are 0):
  - phase 0: sel=1.
  - phase 1: sel=1, rd=1.
  - phases 2–3: sel=1, rd=1, ld_ir=1.
  - phase 4: sel=0; inc_pc = (opcode != HLT); halt = (opcode == HLT).
  - phase 5: rd = ALUOP.
  - phase 6: rd = ALUOP; inc_pc = (opcode==SKZ && is_zero); ld_pc = (opcode==JMP); data_e = (opcode==STO).
  - phase 7: rd = ALUOP; ld_ac = ALUOP; ld_pc = (opcode==JMP); wr = (opcode==STO); data_e = (opcode==STO).
- Opcode timing
  - opcode is don't-care in phases 0–2.
  - It must be stable from phase 3 to phase 7.
  - is_zero is sampled only in phase 6.
- Halt handling
  - HALT_STICKY=1: at the clk edge ending phase 4 with opcode==HLT, halted is set.
  - While halted: phase stays 5, halt=1, every other strobe 0, sel=0.
  - Only rst clears halted.
  - HALT_STICKY=0: halt is high only during phase 4 and the sequence continues normally.
- Boundary conditions
  - SKZ with is_zero=0: no strobe in phases 5–7 (pure 8-cycle NOP).
  - Unknown or X opcode is not possible with a 3-bit field; all 8 codes are decoded.
  - rst mid-instruction (any phase, including halted) returns to phase 0 immediately.
  - No partial wr: wr may only be high in phase 7, and rst drops it at once.
  - wr and rd are never high in the same phase; ld_pc and inc_pc are never high together.

Decomposition:
- Shared header (existing opcode defines file):
  - `OPCODE_*` codes.
  - New `PHASE_*` encodings 0..7.
  - An `IS_ALUOP` helper macro.
- One natural sub-module: cpu_phase_counter.
  - 3-bit wrapping counter with async reset and hold input.
  - cpu_controller instantiates it and holds the halted flag plus the output decode.

Test Plan:
- Reset then free run with opcode=ADD, is_zero=0 -> phase steps 0..7 repeatedly; ld_ir high in phases 2–3; rd high in phases 1,2,3,5,6,7; ld_ac only in phase 7; inc_pc only in phase 4.
- opcode=SKZ, is_zero=1 -> inc_pc high in phase 4 and phase 6 (two pulses per instruction). Repeat with is_zero=0 -> single pulse in phase 4.
- opcode=JMP -> ld_pc high in phases 6 and 7, inc_pc only in phase 4, rd never high after phase 3.
- opcode=STO -> data_e high in phases 6–7, wr high only in phase 7, rd and ld_ac 0 in phases 5–7.
- opcode=HLT, HALT_STICKY=1 -> halt rises in phase 4 with inc_pc=0; phase frozen at 5 for 20+ clocks; assert rst -> phase=0, halt=0, sel=1 immediately.
- Assert rst asynchronously mid-phase 7 of STO -> wr drops before the next clk edge; after release the sequence restarts at phase 0.

Source files
------------

// File: rtl/cpu_controller_pkg.sv
// Shared opcode and phase encodings for the accumulator CPU sequencer.
package cpu_controller_pkg;

  localparam logic [2:0] OPCODE_HLT = 3'd0;
  localparam logic [2:0] OPCODE_SKZ = 3'd1;
  localparam logic [2:0] OPCODE_ADD = 3'd2;
  localparam logic [2:0] OPCODE_AND = 3'd3;
  localparam logic [2:0] OPCODE_XOR = 3'd4;
  localparam logic [2:0] OPCODE_LDA = 3'd5;
  localparam logic [2:0] OPCODE_STO = 3'd6;
  localparam logic [2:0] OPCODE_JMP = 3'd7;

  localparam logic [2:0] PHASE_INST_ADDR  = 3'd0;
  localparam logic [2:0] PHASE_INST_FETCH = 3'd1;
  localparam logic [2:0] PHASE_INST_LOAD  = 3'd2;
  localparam logic [2:0] PHASE_IDLE       = 3'd3;
  localparam logic [2:0] PHASE_OP_ADDR    = 3'd4;
  localparam logic [2:0] PHASE_OP_FETCH   = 3'd5;
  localparam logic [2:0] PHASE_ALU_OP     = 3'd6;
  localparam logic [2:0] PHASE_STORE      = 3'd7;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OPCODE_ADD) || (op == OPCODE_AND) ||
           (op == OPCODE_XOR) || (op == OPCODE_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_phase_counter.sv
// 3-bit wrapping phase counter with asynchronous reset and hold.
module cpu_phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [2:0] phase
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= '0;
    else if (!hold)
      phase <= phase + 3'd1;
  end

endmodule

// File: rtl/cpu_controller.sv
// 8-phase instruction sequencer: halted flag plus combinational strobe decode.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       is_zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       wr,
  output logic       halt,
  output logic [2:0] phase
);

  logic halted;
  logic aluop;

  cpu_phase_counter u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .hold  (halted),
    .phase (phase)
  );

  // The counter steps to OP_FETCH on the same edge that sets halted, so it freezes at 5.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted <= 1'b0;
    else if (HALT_STICKY && (phase == PHASE_OP_ADDR) && (opcode == OPCODE_HLT))
      halted <= 1'b1;
  end

  assign aluop = is_aluop(opcode);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase)
        PHASE_INST_ADDR: begin
          sel = 1'b1;
        end
        PHASE_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PHASE_INST_LOAD, PHASE_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PHASE_OP_ADDR: begin
          inc_pc = (opcode != OPCODE_HLT);
          halt   = (opcode == OPCODE_HLT);
        end
        PHASE_OP_FETCH: begin
          rd = aluop;
        end
        PHASE_ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OPCODE_SKZ) && is_zero;
          ld_pc  = (opcode == OPCODE_JMP);
          data_e = (opcode == OPCODE_STO);
        end
        default: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OPCODE_JMP);
          wr     = (opcode == OPCODE_STO);
          data_e = (opcode == OPCODE_STO);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller against a phase-rule reference model.
module tb_cpu_controller;

  localparam int HLT = 0, SKZ = 1, ADD = 2, AND_ = 3, XOR_ = 4, LDA = 5, STO = 6, JMP = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'(ADD);
  logic       is_zero = 1'b0;
  logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [2:0] phase;
  logic [11:0] obs;

  int n_checks = 0;
  int n_pass   = 0;
  int m_phase  = 0;
  bit m_halted = 0;

  cpu_controller #(.HALT_STICKY(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  assign obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase};

  // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr,halt,phase} from the phase table.
  function automatic logic [11:0] model_out(int ph, int op, logic z, bit hlt);
    bit alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    bit s = 0, r = 0, li = 0, ip = 0, lp = 0, la = 0, de = 0, w = 0, h = 0;
    if (hlt) begin
      h = 1;
    end else begin
      s  = (ph <= 3);
      r  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      li = (ph == 2 || ph == 3);
      ip = (ph == 4 && op != HLT) || (ph == 6 && op == SKZ && z);
      lp = (ph >= 6 && op == JMP);
      la = (ph == 7 && alu);
      de = (ph >= 6 && op == STO);
      w  = (ph == 7 && op == STO);
      h  = (ph == 4 && op == HLT);
    end
    return {s, r, li, ip, lp, la, de, w, h, 3'(ph)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!m_halted) begin
      if (m_phase == 4 && int'(opcode) == HLT) m_halted = 1;
      m_phase = (m_phase + 1) % 8;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_phase = 0;
    m_halted = 0;
    #1;
  endtask

  task automatic align_phase0();
    for (int i = 0; i < 8 && m_phase != 0; i++) tick();
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    rst = 1'b1;
    #1;
    exp = {1'b1, 8'b0, 3'd0};
    n_checks++;
    if (obs !== exp) $display("FAIL reset_state: got %b want %b", obs, exp);
    else n_pass++;
    apply_reset();
    n_checks++;
    if (obs !== exp) $display("FAIL after_reset_release: got %b want %b", obs, exp);
    else n_pass++;
  endtask

  task automatic test_free_run_add();
    logic [11:0] exp;
    opcode = 3'(ADD);
    for (int c = 0; c < 24; c++) begin
      is_zero = 1'($urandom_range(0, 1));
      #1;
      exp = model_out(m_phase, ADD, is_zero, m_halted);
      n_checks++;
      if (obs !== exp) $display("FAIL add_cycle%0d: got %b want %b", c, obs, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_skz();
    logic [11:0] exp;
    int pulses;
    align_phase0();
    opcode = 3'(SKZ);
    for (int pass = 0; pass < 2; pass++) begin
      is_zero = (pass == 0);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
        #1;
        exp = model_out(m_phase, SKZ, is_zero, m_halted);
        if (inc_pc === 1'b1) pulses++;
        n_checks++;
        if (obs !== exp) $display("FAIL skz_z%0d_ph%0d: got %b want %b", is_zero, m_phase, obs, exp);
        else n_pass++;
        tick();
      end
      n_checks++;
      if (pulses != (is_zero ? 2 : 1))
        $display("FAIL skz_inc_pulses_z%0d: got %0d want %0d", is_zero, pulses, is_zero ? 2 : 1);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    align_phase0();
    for (int c = 0; c < 400; c++) begin
      if (m_phase <= 2 && $urandom_range(0, 2) == 0) opcode = 3'($urandom_range(1, 7));
      is_zero = 1'($urandom_range(0, 1));
      #1;
      exp = model_out(m_phase, int'(opcode), is_zero, m_halted);
      n_checks++;
      if (obs !== exp) $display("FAIL rand_op%0d_ph%0d: got %b want %b", opcode, m_phase, obs, exp);
      else n_pass++;
      n_checks++;
      if ((rd && wr) || (ld_pc && inc_pc))
        $display("FAIL rand_exclusive: got rd=%b wr=%b ld_pc=%b inc_pc=%b want no overlap", rd, wr, ld_pc, inc_pc);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_halt();
    logic [11:0] exp;
    align_phase0();
    opcode = 3'(HLT);
    for (int c = 0; c < 30; c++) begin
      is_zero = 1'($urandom_range(0, 1));
      #1;
      exp = model_out(m_phase, HLT, is_zero, m_halted);
      n_checks++;
      if (obs !== exp) $display("FAIL halt_cycle%0d: got %b want %b", c, obs, exp);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (phase !== 3'd5 || halt !== 1'b1)
      $display("FAIL halt_frozen: got phase=%0d halt=%b want phase=5 halt=1", phase, halt);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    exp = {1'b1, 8'b0, 3'd0};
    n_checks++;
    if (obs !== exp) $display("FAIL halt_async_reset: got %b want %b", obs, exp);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_sto_reset();
    logic [11:0] exp;
    opcode = 3'(STO);
    for (int c = 0; c < 8 && m_phase != 7; c++) begin
      #1;
      exp = model_out(m_phase, STO, is_zero, m_halted);
      n_checks++;
      if (obs !== exp) $display("FAIL sto_ph%0d: got %b want %b", m_phase, obs, exp);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (wr !== 1'b1 || data_e !== 1'b1 || phase !== 3'd7)
      $display("FAIL sto_store_phase: got wr=%b data_e=%b phase=%0d want 1 1 7", wr, data_e, phase);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    exp = {1'b1, 8'b0, 3'd0};
    n_checks++;
    if (obs !== exp) $display("FAIL sto_async_reset: got %b want %b", obs, exp);
    else n_pass++;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      #1;
      exp = model_out(m_phase, STO, is_zero, m_halted);
      n_checks++;
      if (obs !== exp) $display("FAIL sto_restart_cycle%0d: got %b want %b", c, obs, exp);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_free_run_add();
    test_skz();
    test_random();
    test_halt();
    test_sto_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
